// File: rtl/flash_writer_pkg.sv
// flash_writer_pkg: opcodes, reset-sequence length and FSM states
// shared by the SPI erase/program engine and the dual-IO read path.
package flash_writer_pkg;

   localparam logic [7:0] CMD_WREN   = 8'h06;
   localparam logic [7:0] CMD_SE     = 8'h20;
   localparam logic [7:0] CMD_PP     = 8'h02;
   localparam logic [7:0] CMD_RDSR1  = 8'h05;
   localparam logic [7:0] CMD_RD_DIO = 8'hBB;

   localparam int MRST_BITS = 16;

   typedef enum logic [2:0] {
      IDLE,
      MRST,
      GAP,
      WREN,
      CMD,
      DATA,
      POLL,
      END
   } state_t;

endpackage

// File: rtl/spi_shift8.sv
// spi_shift8: 8-bit MSB-first shifter with parallel load and serial capture.
// Ports: load/load_data, shift, sin in; sout (current bit), last (8th bit).
module spi_shift8 (
   input  logic       clk,
   input  logic       resetn,
   input  logic       load,
   input  logic [7:0] load_data,
   input  logic       shift,
   input  logic       sin,
   output logic       sout,
   output logic       last
);

   logic [7:0] sr;
   logic [2:0] cnt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sr  <= 8'hFF;
         cnt <= 3'd0;
      end else if (load) begin
         sr  <= load_data;
         cnt <= 3'd0;
      end else if (shift) begin
         sr  <= {sr[6:0], sin};
         cnt <= cnt + 3'd1;
      end
   end

   assign sout = sr[7];
   assign last = (cnt == 3'd7);

endmodule

// File: rtl/flash_writer.sv
// flash_writer: single-bit SPI sector-erase / page-program engine (W25Q64FV).
// Ports: erase/write start, address/len/din host data, din_ack, busy/done/error, mspi_* pins.
module flash_writer
   import flash_writer_pkg::*;
#(
   parameter int CS_GAP        = 4,
   parameter int TIMEOUT_BYTES = 4194303
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [23:0] address,
   input  logic        erase,
   input  logic        write,
   input  logic [7:0]  len,
   input  logic [7:0]  din,
   output logic        din_ack,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic        mspi_cs,
   output logic        mspi_di,
   input  logic        mspi_do,
   output logic        mspi_hold,
   output logic        mspi_wp
);

   localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);
   localparam logic [21:0]   TMO_LAST = 22'(TIMEOUT_BYTES - 1);
   localparam logic [3:0]    MRST_LAST = 4'(MRST_BITS - 1);

   state_t        state, state_n;
   state_t        ret, ret_n;
   logic [3:0]    bit_cnt, bit_cnt_n;
   logic [GW-1:0] gap_cnt, gap_cnt_n;
   logic [8:0]    byte_cnt, byte_cnt_n;
   logic [8:0]    nbytes, nbytes_n;
   logic [21:0]   tmo_cnt, tmo_cnt_n;
   logic [23:0]   addr_q, addr_n;
   logic          pp, pp_n;
   logic          err_q, err_n;

   logic          shifting;
   logic          sh_load, sh_shift, sh_out, sh_last;
   logic [7:0]    sh_data;

   assign shifting = (state == WREN) || (state == CMD) ||
                     (state == DATA) || (state == POLL);

   spi_shift8 u_shift (
      .clk       (clk),
      .resetn    (resetn),
      .load      (sh_load),
      .load_data (sh_data),
      .shift     (sh_shift),
      .sin       (mspi_do),
      .sout      (sh_out),
      .last      (sh_last)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         ret      <= IDLE;
         bit_cnt  <= '0;
         gap_cnt  <= '0;
         byte_cnt <= '0;
         nbytes   <= '0;
         tmo_cnt  <= '0;
         addr_q   <= '0;
         pp       <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_n;
         ret      <= ret_n;
         bit_cnt  <= bit_cnt_n;
         gap_cnt  <= gap_cnt_n;
         byte_cnt <= byte_cnt_n;
         nbytes   <= nbytes_n;
         tmo_cnt  <= tmo_cnt_n;
         addr_q   <= addr_n;
         pp       <= pp_n;
         err_q    <= err_n;
      end
   end

   always_comb begin
      state_n    = state;
      ret_n      = ret;
      bit_cnt_n  = bit_cnt;
      gap_cnt_n  = gap_cnt;
      byte_cnt_n = byte_cnt;
      nbytes_n   = nbytes;
      tmo_cnt_n  = tmo_cnt;
      addr_n     = addr_q;
      pp_n       = pp;
      err_n      = err_q;
      sh_load    = 1'b0;
      sh_shift   = 1'b0;
      sh_data    = 8'h00;
      din_ack    = 1'b0;

      unique case (state)
         IDLE: begin
            if (erase || write) begin
               state_n   = MRST;
               bit_cnt_n = '0;
               err_n     = 1'b0;
               pp_n      = !erase;
               addr_n    = erase ? {address[23:12], 12'h000} : address;
               nbytes_n  = (len == 8'd0) ? 9'd256 : {1'b0, len};
            end
         end
         MRST: begin
            if (bit_cnt == MRST_LAST) begin
               state_n   = GAP;
               gap_cnt_n = '0;
               ret_n     = WREN;
            end else begin
               bit_cnt_n = bit_cnt + 4'd1;
            end
         end
         GAP: begin
            if (gap_cnt == GAP_LAST) begin
               state_n    = ret;
               byte_cnt_n = '0;
               sh_load    = 1'b1;
               unique case (1'b1)
                  (ret == WREN): sh_data = CMD_WREN;
                  (ret == CMD):  sh_data = pp ? CMD_PP : CMD_SE;
                  default:       sh_data = CMD_RDSR1;
               endcase
            end else begin
               gap_cnt_n = gap_cnt + GW'(1);
            end
         end
         WREN: begin
            if (sh_last) begin
               state_n   = GAP;
               gap_cnt_n = '0;
               ret_n     = CMD;
            end
         end
         CMD: begin
            if (sh_last) begin
               if (byte_cnt == 9'd3) begin
                  byte_cnt_n = '0;
                  if (pp) begin
                     state_n = DATA;
                     sh_load = 1'b1;
                     sh_data = din;
                     din_ack = 1'b1;
                  end else begin
                     state_n   = GAP;
                     gap_cnt_n = '0;
                     ret_n     = POLL;
                  end
               end else begin
                  byte_cnt_n = byte_cnt + 9'd1;
                  sh_load    = 1'b1;
                  unique case (byte_cnt[1:0])
                     2'd0:    sh_data = addr_q[23:16];
                     2'd1:    sh_data = addr_q[15:8];
                     default: sh_data = addr_q[7:0];
                  endcase
               end
            end
         end
         DATA: begin
            if (sh_last) begin
               if (byte_cnt == nbytes - 9'd1) begin
                  state_n   = GAP;
                  gap_cnt_n = '0;
                  ret_n     = POLL;
               end else begin
                  byte_cnt_n = byte_cnt + 9'd1;
                  sh_load    = 1'b1;
                  sh_data    = din;
                  din_ack    = 1'b1;
               end
            end
         end
         POLL: begin
            // byte_cnt 0 is the RDSR1 opcode, then status bytes.
            // BUSY is the status LSB, so it is the bit arriving on
            // mspi_do at the edge that completes the byte.
            if (sh_last) begin
               if (byte_cnt == 9'd0) begin
                  byte_cnt_n = 9'd1;
                  tmo_cnt_n  = '0;
                  sh_load    = 1'b1;
               end else if (!mspi_do) begin
                  state_n = END;
               end else if (tmo_cnt == TMO_LAST) begin
                  tmo_cnt_n = tmo_cnt + 22'd1;
                  err_n     = 1'b1;
                  state_n   = END;
               end else begin
                  tmo_cnt_n = tmo_cnt + 22'd1;
                  sh_load   = 1'b1;
               end
            end
         end
         END: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      sh_shift = shifting && !sh_load;
   end

   assign busy      = (state != IDLE) && (state != END);
   assign done      = (state == END);
   assign error     = err_q;
   assign mspi_cs   = !(shifting || (state == MRST));
   assign mspi_di   = shifting ? sh_out : 1'b1;
   assign mspi_hold = 1'b1;
   assign mspi_wp   = 1'b1;

endmodule

// File: tb/tb_flash_writer.sv
// tb_flash_writer: random stimulus against a behavioural W25Q64 model
// that decodes each cs-low frame into opcode, address and data bytes.
module tb_flash_writer;

   localparam int GAP = 4;
   localparam int TMO = 10;
   localparam int LIM = 6000;

   logic        clk;
   logic        resetn;
   logic [23:0] address;
   logic        erase;
   logic        write;
   logic [7:0]  len;
   logic [7:0]  din;
   logic        din_ack;
   logic        busy;
   logic        done;
   logic        error;
   logic        mspi_cs;
   logic        mspi_di;
   logic        mspi_do;
   logic        mspi_hold;
   logic        mspi_wp;

   flash_writer #(
      .CS_GAP        (GAP),
      .TIMEOUT_BYTES (TMO)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .address   (address),
      .erase     (erase),
      .write     (write),
      .len       (len),
      .din       (din),
      .din_ack   (din_ack),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .mspi_cs   (mspi_cs),
      .mspi_di   (mspi_di),
      .mspi_do   (mspi_do),
      .mspi_hold (mspi_hold),
      .mspi_wp   (mspi_wp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // host side: show-ahead byte source
   logic [7:0] host_data [0:511];
   int ack_total = 0;
   int base = 0;
   int busy_cyc = 0;
   int done_cnt = 0;

   assign din = host_data[9'(ack_total - base)];

   always @(posedge clk) begin
      if (busy) busy_cyc++;
      if (done) done_cnt++;
      if (din_ack) ack_total <= ack_total + 1;
   end

   // flash model
   logic       bq [$];
   int         busy_n = 0;
   bit         busy_forever = 1'b0;
   logic [7:0] mem [int];
   logic [7:0] ev_op [$];
   int         ev_bits [$];
   logic [23:0] ev_addr [$];

   function automatic logic [7:0] get_byte(input int i);
      logic [7:0] b;
      b = 8'h00;
      for (int k = 0; k < 8; k++) b = {b[6:0], bq[8*i+k]};
      return b;
   endfunction

   task automatic decode();
      int nb;
      logic [7:0] op;
      logic [23:0] a;
      nb = bq.size();
      op = (nb >= 8) ? get_byte(0) : 8'h00;
      a = 24'h0;
      for (int i = 1; i <= 3; i++)
         if (nb >= 8*(i+1)) a = {a[15:0], get_byte(i)};
      ev_op.push_back(op);
      ev_bits.push_back(nb);
      ev_addr.push_back(a);
      if (op == 8'h02 && nb >= 32)
         for (int i = 0; i < (nb - 32) / 8; i++)
            mem[int'({a[23:8], 8'(a[7:0] + 8'(i))})] = get_byte(4 + i);
   endtask

   always @(posedge clk) begin
      if (!mspi_cs) bq.push_back(mspi_di);
      else if (bq.size() != 0) begin
         decode();
         bq.delete();
      end
   end

   always @(negedge clk) begin : drv
      int j;
      mspi_do = 1'($urandom_range(0, 1));
      if (!mspi_cs && bq.size() >= 8) begin
         if (get_byte(0) == 8'h05) begin
            j = bq.size() - 8;
            if (j % 8 == 7)
               mspi_do = busy_forever || ((j / 8) < busy_n);
         end
      end
   end

   task automatic start_op(input logic er, input logic wr,
                           input logic [23:0] a, input logic [7:0] l);
      @(negedge clk);
      ev_op.delete();
      ev_bits.delete();
      ev_addr.delete();
      busy_cyc = 0;
      done_cnt = 0;
      base = ack_total;
      erase = er;
      write = wr;
      address = a;
      len = l;
      @(negedge clk);
      erase = 1'b0;
      write = 1'b0;
   endtask

   task automatic wait_done(input string t);
      int n;
      n = 0;
      while (!done && n < LIM) begin
         @(negedge clk);
         n++;
      end
      chk({t, ":done_seen"}, 32'(n < LIM), 1);
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic check_seq(input string t, input bit is_pp,
                            input logic [23:0] a, input int n,
                            input int k, input bit err);
      int lat;
      lat = 16 + 8 + 32 + 8*n + 8 + 8*k + 3*GAP + 1;
      chk({t, ":frames"}, ev_op.size(), 4);
      if (ev_op.size() >= 4) begin
         chk({t, ":mrst_bits"}, ev_bits[0], 16);
         chk({t, ":mrst_ones"}, {ev_op[0], ev_addr[0]}, 32'hFF0000FF);
         chk({t, ":wren_op"}, 32'(ev_op[1]), 32'h06);
         chk({t, ":wren_bits"}, ev_bits[1], 8);
         chk({t, ":cmd_op"}, 32'(ev_op[2]), is_pp ? 32'h02 : 32'h20);
         chk({t, ":cmd_bits"}, ev_bits[2], 32 + 8*n);
         chk({t, ":cmd_addr"}, 32'(ev_addr[2]),
             is_pp ? 32'(a) : 32'({a[23:12], 12'h000}));
         chk({t, ":rdsr_op"}, 32'(ev_op[3]), 32'h05);
         chk({t, ":rdsr_bits"}, ev_bits[3], 8 + 8*k);
      end
      chk({t, ":done_cnt"}, done_cnt, 1);
      chk({t, ":busy_cyc"}, busy_cyc, lat - 1);
      chk({t, ":acks"}, ack_total - base, n);
      chk({t, ":error"}, 32'(error), 32'(err));
      chk({t, ":cs_idle"}, 32'(mspi_cs), 1);
   endtask

   task automatic check_mem(input string t, input logic [23:0] a,
                            input int n);
      for (int i = 0; i < n; i++)
         chk(t, 32'(mem[int'({a[23:8], 8'(a[7:0] + 8'(i))})]),
             32'(host_data[i]));
   endtask

   initial begin
      logic [23:0] a;
      int n;
      int k;
      int t;

      resetn = 1'b0;
      erase = 1'b0;
      write = 1'b0;
      address = 24'h0;
      len = 8'h0;
      mspi_do = 1'b0;
      for (int i = 0; i < 512; i++) host_data[i] = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_cs", 32'(mspi_cs), 1);
      chk("rst_di", 32'(mspi_di), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_ack", 32'(din_ack), 0);
      chk("rst_err", 32'(error), 0);
      chk("rst_holdwp", {30'h0, mspi_hold, mspi_wp}, 3);
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      // erase, 3 busy status bytes
      busy_n = 3;
      start_op(1'b1, 1'b0, 24'h123456, 8'd0);
      wait_done("erase");
      check_seq("erase", 1'b0, 24'h123456, 0, 4, 1'b0);

      // program 3 bytes
      host_data[0] = 8'hA5;
      host_data[1] = 8'h5A;
      host_data[2] = 8'hFF;
      busy_n = 1;
      start_op(1'b0, 1'b1, 24'h0400F0, 8'd3);
      wait_done("pp3");
      check_seq("pp3", 1'b1, 24'h0400F0, 3, 2, 1'b0);
      check_mem("pp3_mem", 24'h0400F0, 3);

      // program 256 bytes (len 0), wrapping inside the page
      for (int i = 0; i < 256; i++) host_data[i] = 8'($urandom);
      a = 24'($urandom);
      busy_n = 0;
      start_op(1'b0, 1'b1, a, 8'd0);
      wait_done("pp256");
      check_seq("pp256", 1'b1, a, 256, 1, 1'b0);
      check_mem("pp256_mem", a, 256);

      // random programs
      for (int it = 0; it < 4; it++) begin
         a = 24'($urandom);
         n = $urandom_range(1, 40);
         k = $urandom_range(0, 4);
         for (int i = 0; i < n; i++) host_data[i] = 8'($urandom);
         busy_n = k;
         start_op(1'b0, 1'b1, a, 8'(n));
         wait_done("ppr");
         check_seq("ppr", 1'b1, a, n, k + 1, 1'b0);
         check_mem("ppr_mem", a, n);
      end

      // erase and write together, then write pulsed while busy
      a = 24'($urandom);
      busy_n = 2;
      start_op(1'b1, 1'b1, a, 8'd5);
      repeat (40) @(negedge clk);
      write = 1'b1;
      len = 8'd7;
      @(negedge clk);
      write = 1'b0;
      wait_done("both");
      check_seq("both", 1'b0, a, 0, 3, 1'b0);
      n = 0;
      foreach (ev_op[i]) if (ev_op[i] == 8'h02) n++;
      chk("both:no_pp", n, 0);
      busy_cyc = 0;
      repeat (20) @(negedge clk);
      chk("busy_write_ignored", busy_cyc, 0);

      // poll timeout
      busy_forever = 1'b1;
      a = 24'($urandom);
      start_op(1'b1, 1'b0, a, 8'd0);
      wait_done("tmo");
      check_seq("tmo", 1'b0, a, 0, TMO, 1'b1);
      busy_forever = 1'b0;
      busy_n = 0;
      start_op(1'b1, 1'b0, a, 8'd0);
      chk("tmo:err_clr", 32'(error), 0);
      chk("tmo:busy_set", 32'(busy), 1);
      wait_done("tmo2");
      check_seq("tmo2", 1'b0, a, 0, 1, 1'b0);

      // reset during the second data byte
      for (int i = 0; i < 8; i++) host_data[i] = 8'($urandom);
      busy_n = 0;
      start_op(1'b0, 1'b1, 24'($urandom), 8'd5);
      t = 0;
      while ((ack_total - base) < 2 && t < LIM) begin
         @(negedge clk);
         t++;
      end
      chk("rst_mid:ack2", 32'(t < LIM), 1);
      repeat (3) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("rst_mid:cs", 32'(mspi_cs), 1);
      chk("rst_mid:busy", 32'(busy), 0);
      chk("rst_mid:ack", 32'(din_ack), 0);
      @(negedge clk);
      resetn = 1'b1;
      a = 24'($urandom);
      busy_n = 1;
      start_op(1'b1, 1'b0, a, 8'd0);
      wait_done("after_rst");
      check_seq("after_rst", 1'b0, a, 0, 2, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule
